// File: rtl/ex_mem_reg.sv
// EX->MEM pipeline register with MADD/MSUB product/counter feedback to EX.
// Latency: exactly 1 cycle EX->MEM; every output is a flop, no input-to-output path.
// Stall: stall_ex alone inserts a NOP into MEM; stall_ex with stall_mem holds MEM.
module ex_mem_reg #(
   parameter int REG_W  = 32,
   parameter int ADDR_W = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 stall_ex,
   input  logic                 stall_mem,
   input  logic [ADDR_W-1:0]    ex_wd,
   input  logic                 ex_wreg,
   input  logic [REG_W-1:0]     ex_wdata,
   input  logic                 ex_whilo,
   input  logic [REG_W-1:0]     ex_hi,
   input  logic [REG_W-1:0]     ex_lo,
   input  logic [2*REG_W-1:0]   hilo_i,
   input  logic [1:0]           cnt_i,
   output logic [ADDR_W-1:0]    mem_wd,
   output logic                 mem_wreg,
   output logic [REG_W-1:0]     mem_wdata,
   output logic                 mem_whilo,
   output logic [REG_W-1:0]     mem_hi,
   output logic [REG_W-1:0]     mem_lo,
   output logic [2*REG_W-1:0]   hilo_o,
   output logic [1:0]           cnt_o
);

   // Everything MEM consumes, kept together so NOP/hold act on it as one unit.
   typedef struct packed {
      logic [ADDR_W-1:0] wd;
      logic              wreg;
      logic [REG_W-1:0]  wdata;
      logic              whilo;
      logic [REG_W-1:0]  hi;
      logic [REG_W-1:0]  lo;
   } mem_payload_t;

   mem_payload_t         mem_q, mem_d;
   logic [2*REG_W-1:0]   hilo_q, hilo_d;
   logic [1:0]           cnt_q, cnt_d;

   // Next-state selection: flush > advance > bubble > hold. The unreachable
   // stall_ex=0/stall_mem=1 case falls into hold so MEM never loses data.
   always_comb begin
      mem_d  = mem_q;
      hilo_d = hilo_q;
      cnt_d  = cnt_q;
      if (flush) begin
         // Discards any MADD/MSUB in flight so EX restarts cleanly.
         mem_d  = '0;
         hilo_d = '0;
         cnt_d  = '0;
      end else if (!stall_ex && !stall_mem) begin
         // Instruction leaves EX; multi-cycle state is no longer needed.
         mem_d.wd    = ex_wd;
         mem_d.wreg  = ex_wreg;
         mem_d.wdata = ex_wdata;
         mem_d.whilo = ex_whilo;
         mem_d.hi    = ex_hi;
         mem_d.lo    = ex_lo;
         hilo_d      = '0;
         cnt_d       = '0;
      end else if (stall_ex && !stall_mem) begin
         // Bubble into MEM while EX's partial product loops back for next cycle.
         mem_d  = '0;
         hilo_d = hilo_i;
         cnt_d  = cnt_i;
      end else begin
         // MEM frozen; EX is still stalled so keep carrying its partial state.
         hilo_d = hilo_i;
         cnt_d  = cnt_i;
      end
   end

   // State register with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q  <= '0;
         hilo_q <= '0;
         cnt_q  <= '0;
      end else begin
         mem_q  <= mem_d;
         hilo_q <= hilo_d;
         cnt_q  <= cnt_d;
      end
   end

   assign mem_wd    = mem_q.wd;
   assign mem_wreg  = mem_q.wreg;
   assign mem_wdata = mem_q.wdata;
   assign mem_whilo = mem_q.whilo;
   assign mem_hi    = mem_q.hi;
   assign mem_lo    = mem_q.lo;
   assign hilo_o    = hilo_q;
   assign cnt_o     = cnt_q;

endmodule
